// File: rtl/instr_enc_pkg.sv
// Shared encoding constants for the instruction loader and the pipeline decoder.
package instr_enc_pkg;

    // Symbolic operations understood by the loader; codes 12-15 are invalid
    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_SLLI = 4'd1,
        OP_BEQ  = 4'd2,
        OP_BNE  = 4'd3,
        OP_SW   = 4'd4,
        OP_SB   = 4'd5,
        OP_LW   = 4'd6,
        OP_LBU  = 4'd7,
        OP_JAL  = 4'd8,
        OP_JALR = 4'd9,
        OP_LUI  = 4'd10,
        OP_ADD  = 4'd11
    } op_e;

    // Loader session states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        FULL = 2'd3
    } state_e;

    // Major opcodes
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 values
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // True when value[31:msb] are all equal, i.e. value is a sign extension
    // of its low msb+1 bits
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned msb);
        logic [31:0] upper;
        upper = $signed(value) >>> msb;
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32I encoder for the decoder-supported subset.
// range_err flags anything that cannot be encoded faithfully: an immediate
// outside its field, a misaligned branch/jump offset, or an unknown op.
module instr_encoder
    import instr_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err
);

    // Assemble the instruction word and check the immediate for its format
    always_comb begin
        word      = NOP;
        range_err = 1'b0;
        case (op)
            OP_ADDI: begin
                word      = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
                range_err = !fits_signed(imm, 11);
            end
            OP_SLLI: begin
                word      = {F7_ZERO, imm[4:0], rs1, F3_SLLI, rd, OPC_OPIMM};
                range_err = (imm[31:5] != '0);
            end
            OP_BEQ: begin
                word      = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                range_err = !fits_signed(imm, 12) || imm[0];
            end
            OP_BNE: begin
                word      = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
                range_err = !fits_signed(imm, 12) || imm[0];
            end
            OP_SW: begin
                word      = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
                range_err = !fits_signed(imm, 11);
            end
            OP_SB: begin
                word      = {imm[11:5], rs2, rs1, F3_SB, imm[4:0], OPC_STORE};
                range_err = !fits_signed(imm, 11);
            end
            OP_LW: begin
                word      = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
                range_err = !fits_signed(imm, 11);
            end
            OP_LBU: begin
                word      = {imm[11:0], rs1, F3_LBU, rd, OPC_LOAD};
                range_err = !fits_signed(imm, 11);
            end
            OP_JAL: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                range_err = !fits_signed(imm, 20) || imm[0];
            end
            OP_JALR: begin
                word      = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
                range_err = !fits_signed(imm, 11);
            end
            OP_LUI: begin
                word      = {imm[31:12], rd, OPC_LUI};
                range_err = (imm[11:0] != '0);
            end
            OP_ADD: begin
                word      = {F7_ZERO, rs2, rs1, F3_ADD, rd, OPC_OP};
                range_err = 1'b0;
            end
            default: begin
                word      = NOP;
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction requests and writes their RV32I encodings
// sequentially into instruction memory, one word per accepted request.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    finish,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_op,
    input  logic [4:0]              req_rd,
    input  logic [4:0]              req_rs1,
    input  logic [4:0]              req_rs2,
    input  logic [31:0]             req_imm,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy,
    output logic                    full,
    output logic                    done,
    output logic                    err
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    state_e        state_q;
    state_e        state_d;
    logic          we_q;
    logic          xfer;
    logic          last_word;
    logic [31:0]   enc_word;
    logic          enc_err;

    instr_encoder u_enc (
        .op        (req_op),
        .rd        (req_rd),
        .rs1       (req_rs1),
        .rs2       (req_rs2),
        .imm       (req_imm),
        .word      (enc_word),
        .range_err (enc_err)
    );

    // A start in the same cycle would clear the counter, so no request is
    // accepted then; nothing is accepted while reset is asserted either.
    assign req_ready = rst_n && (state_q == LOAD) && (count < DEPTH_C) && !start;
    assign xfer      = req_valid && req_ready;
    assign last_word = xfer && (count == DEPTH_C - 1'b1);
    assign busy      = (state_q == LOAD);
    // A write still in flight when reset arrives never reaches memory
    assign mem_we    = we_q && rst_n;

    // Session state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start wins, then finish, then running out of space
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LOAD;
        end else if (state_q == LOAD) begin
            if (finish) begin
                state_d = DONE;
            end else if (last_word) begin
                state_d = FULL;
            end
        end
    end

    // Write port, word counter and session status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
            done      <= 1'b0;
        end else begin
            we_q <= xfer;
            if (start) begin
                count <= '0;
                err   <= 1'b0;
                full  <= 1'b0;
                done  <= 1'b0;
            end else begin
                if (xfer) begin
                    mem_addr  <= BASE_ADDR + (ADDR_WIDTH'(count) << 2);
                    mem_wdata <= enc_word;
                    count     <= count + 1'b1;
                    if (enc_err) begin
                        err <= 1'b1;
                    end
                    if (last_word) begin
                        full <= 1'b1;
                    end
                end
                if ((state_q == LOAD) && finish) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader with a behavioural model.
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  count;
    logic        busy, full, done, err;

    int nChecks = 0;
    int nMiscompares = 0;
    int nWrites = 0;
    bit armed = 0;

    // Model state: mode 0=idle 1=loading 2=finished 3=out of space
    int          mMode = 0;
    int          mCount = 0;
    bit          mWe = 0, mErr = 0, mFull = 0, mDone = 0;
    logic [31:0] mAddr = 0, mWdata = 0;

    instr_encoder_loader #(
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .finish    (finish),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .busy      (busy),
        .full      (full),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference encoding built from field positions with shifts and masks;
    // bit 32 of the result is the "cannot encode faithfully" flag
    function automatic logic [32:0] modelEncode(input int op, input int rd, input int rs1,
                                                input int rs2, input logic [31:0] imm);
        int          s;
        logic [31:0] w;
        bit          bad;
        logic [31:0] r1, r2, d;
        s   = int'(imm);
        r1  = 32'(rs1) << 15;
        r2  = 32'(rs2) << 20;
        d   = 32'(rd) << 7;
        w   = 32'h13;
        bad = 0;
        case (op)
            0, 6, 7, 9: begin
                w = ((imm & 32'hFFF) << 20) | r1 | d;
                case (op)
                    0: w = w | (32'd0 << 12) | 32'h13;
                    6: w = w | (32'd2 << 12) | 32'h03;
                    7: w = w | (32'd4 << 12) | 32'h03;
                    default: w = w | 32'h67;
                endcase
                bad = (s < -2048) || (s > 2047);
            end
            1: begin
                w   = ((imm & 32'h1F) << 20) | r1 | (32'd1 << 12) | d | 32'h13;
                bad = imm > 32'd31;
            end
            2, 3: begin
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 |
                    (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
                if (op == 3) w = w | (32'd1 << 12);
                bad = (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
            end
            4, 5: begin
                w = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | ((imm & 32'h1F) << 7) | 32'h23;
                if (op == 4) w = w | (32'd2 << 12);
                bad = (s < -2048) || (s > 2047);
            end
            8: begin
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                    (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
                bad = (s < -1048576) || (s > 1048575) || (imm[0] == 1'b1);
            end
            10: begin
                w   = (imm & 32'hFFFF_F000) | d | 32'h37;
                bad = (imm & 32'hFFF) != 0;
            end
            11: begin
                w = r2 | r1 | d | 32'h33;
            end
            default: begin
                w   = 32'h0000_0013;
                bad = 1;
            end
        endcase
        return {bad, w};
    endfunction

    function automatic bit modelReady();
        return rst_n && (mMode == 1) && (mCount < DEPTH) && !start;
    endfunction

    // Model advances on each rising edge from the inputs held during the cycle
    always @(posedge clk) begin
        bit          rdy;
        logic [32:0] e;
        rdy = modelReady();
        if (!rst_n) begin
            mMode = 0; mCount = 0; mWe = 0; mErr = 0; mFull = 0; mDone = 0;
            mAddr = 0; mWdata = 0;
            armed = 1;
        end else begin
            mWe = 0;
            if (start) begin
                mMode = 1; mCount = 0; mErr = 0; mFull = 0; mDone = 0;
            end else if (mMode == 1) begin
                if (req_valid && rdy) begin
                    e      = modelEncode(int'(req_op), int'(req_rd), int'(req_rs1), int'(req_rs2), req_imm);
                    mWe    = 1;
                    mAddr  = 32'(4 * mCount);
                    mWdata = e[31:0];
                    if (e[32]) mErr = 1;
                    mCount++;
                    if (mCount == DEPTH) begin
                        mFull = 1;
                        mMode = 3;
                    end
                end
                if (finish) begin
                    mMode = 2;
                    mDone = 1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("mem_we", 32'(mem_we), 32'(mWe && rst_n));
            if (mem_we === 1'b1) nWrites++;
            if (mWe && rst_n) begin
                checkOutput("mem_addr", mem_addr, mAddr);
                checkOutput("mem_wdata", mem_wdata, mWdata);
            end
            checkOutput("count", 32'(count), 32'(mCount));
            checkOutput("busy", 32'(busy), 32'(mMode == 1));
            checkOutput("full", 32'(full), 32'(mFull));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("err", 32'(err), 32'(mErr));
            checkOutput("req_ready", 32'(req_ready), 32'(modelReady()));
        end
    end

    // Drive one cycle of inputs, then release the strobes 1 time unit past the edge
    task automatic applyStimulus(input logic v, input int op, input int rd, input int rs1,
                                 input int rs2, input logic [31:0] imm, input logic st, input logic fin);
        req_valid = v;
        req_op    = 4'(op);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = imm;
        start     = st;
        finish    = fin;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic doStart();
        applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic sendReq(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        applyStimulus(1'b1, op, rd, rs1, rs2, imm, 1'b0, 1'b0);
    endtask

    int xOp[12]  = '{1, 1, 3, 5, 6, 7, 9, 2, 10, 8, 8, 4};
    int xRd[12]  = '{2, 2, 0, 0, 6, 7, 1, 0, 4, 1, 2, 0};
    int xRs1[12] = '{3, 3, 4, 2, 2, 3, 5, 1, 0, 0, 0, 1};
    int xRs2[12] = '{0, 0, 5, 3, 0, 0, 0, 2, 0, 0, 0, 2};
    int xImm[12] = '{7, 40, 16, -1, -8, 2047, -2048, 3, 32'h1001, -2, 32'h100000, 2048};

    initial begin
        int w0;
        rst_n = 1'b0;
        req_valid = 1'b0; start = 1'b0; finish = 1'b0;
        req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Requests before any session are ignored
        sendReq(0, 1, 0, 0, 32'd5);
        checkOutput("idle no write", 32'(mem_we), 32'd0);

        doStart();
        sendReq(0, 1, 0, 0, 32'd5);
        checkOutput("addi word", mem_wdata, 32'h0050_0093);
        checkOutput("addi addr", mem_addr, 32'h0);
        checkOutput("addi count", 32'(count), 32'd1);

        sendReq(11, 3, 1, 2, 32'd0);
        checkOutput("add word", mem_wdata, 32'h0020_81B3);
        checkOutput("add addr", mem_addr, 32'h4);
        sendReq(4, 0, 1, 2, 32'd8);
        checkOutput("sw word", mem_wdata, 32'h0020_A423);
        checkOutput("sw addr", mem_addr, 32'h8);
        sendReq(2, 0, 1, 2, -32'sd4);
        checkOutput("beq word", mem_wdata, 32'hFE20_8EE3);
        checkOutput("beq addr", mem_addr, 32'hC);
        checkOutput("full after 4", 32'(full), 32'd1);
        checkOutput("ready when full", 32'(req_ready), 32'd0);

        doStart();
        sendReq(8, 1, 0, 0, 32'd8);
        checkOutput("jal word", mem_wdata, 32'h0080_00EF);
        sendReq(10, 5, 0, 0, 32'h1234_5000);
        checkOutput("lui word", mem_wdata, 32'h1234_52B7);
        checkOutput("jal/lui err", 32'(err), 32'd0);

        // Hold a request for six cycles with room for only four words
        doStart();
        w0 = nWrites;
        for (int i = 0; i < 6; i++) sendReq(0, i + 1, 0, 0, 32'(i));
        applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
        checkOutput("writes when full", 32'(nWrites - w0), 32'd4);
        checkOutput("full flag", 32'(full), 32'd1);
        checkOutput("full count", 32'(count), 32'd4);
        doStart();
        checkOutput("restart busy", 32'(busy), 32'd1);
        checkOutput("restart count", 32'(count), 32'd0);

        sendReq(0, 1, 0, 0, 32'd2048);
        checkOutput("addi 2048 err", 32'(err), 32'd1);
        checkOutput("addi 2048 word", mem_wdata, 32'h8000_0093);
        sendReq(13, 1, 2, 3, 32'd0);
        checkOutput("invalid op nop", mem_wdata, 32'h0000_0013);
        applyStimulus(1'b1, 11, 1, 2, 3, 32'd0, 1'b0, 1'b1);
        checkOutput("finish word", mem_wdata, 32'h0031_00B3);
        checkOutput("finish done", 32'(done), 32'd1);
        checkOutput("finish count", 32'(count), 32'd3);
        sendReq(0, 1, 0, 0, 32'd1);
        checkOutput("done no write", 32'(mem_we), 32'd0);

        // Remaining ops and range violations, checked by the model
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) doStart();
            sendReq(xOp[i], xRd[i], xRs1[i], xRs2[i], 32'(xImm[i]));
        end

        // Reset arriving right after an accepted request
        doStart();
        sendReq(0, 1, 0, 0, 32'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("we in reset", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("post-reset count", 32'(count), 32'd0);
        checkOutput("post-reset addr", mem_addr, 32'h0);
        checkOutput("post-reset wdata", mem_wdata, 32'h0);
        checkOutput("post-reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        sendReq(0, 1, 0, 0, 32'd5);
        checkOutput("post-reset idle", 32'(mem_we), 32'd0);
        applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
        $finish;
    end

endmodule
